// File: rtl/arbitro_memoria_vga_if.sv
// Display-read, writer and RAM-side signals of the VGA memory arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface arbitro_memoria_vga_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 24
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output disp_data, disp_valid, wr_ready, wr_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  disp_data, disp_valid, wr_ready, wr_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/arbitro_memoria_vga.sv
// Single-port image RAM arbiter: display reads win every cycle they ask;
// buffered writes drain through a small FIFO in the cycles left free.
module arbitro_memoria_vga #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned MEM_WORDS  = 160000,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clock_25,
    input  logic                     reset,
    arbitro_memoria_vga_if.slave     bus,
    input  logic                     frame_start,
    output logic [CNT_W-1:0]         fifo_count,
    output logic [15:0]              stall_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_v1, rd_v2;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic              accept, in_range, push, pop;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              mem_we_nxt;
    logic [CNT_W-1:0]  count_nxt;

    assign bus.wr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

    always_comb begin
        accept        = bus.wr_valid && bus.wr_ready;
        in_range      = 32'(bus.wr_addr) < MEM_WORDS;
        push          = accept && in_range;
        pop           = (state == WR) && (fifo_count != '0);
        mem_addr_nxt  = bus.mem_addr;
        mem_wdata_nxt = bus.mem_wdata;
        mem_we_nxt    = 1'b0;
        state_nxt     = IDLE;

        // The entry popped this cycle is already spoken for, so only schedule
        // another WR if something remains behind it.
        if (bus.disp_req)
            state_nxt = RD;
        else if (fifo_count > CNT_W'(pop))
            state_nxt = WR;

        case (state)
            RD: mem_addr_nxt = rd_addr_q;
            WR: begin
                if (pop) begin
                    mem_addr_nxt  = fifo_addr[rd_ptr];
                    mem_wdata_nxt = fifo_data[rd_ptr];
                    mem_we_nxt    = 1'b1;
                end
            end
            default: ;
        endcase

        count_nxt = fifo_count;
        if (push && !pop)
            count_nxt = fifo_count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = fifo_count - CNT_W'(1);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rd_addr_q      <= '0;
            rd_v1          <= 1'b0;
            rd_v2          <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            stall_cnt      <= '0;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
            bus.wr_err     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_we     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.disp_req)
                rd_addr_q <= bus.disp_addr;

            // Read pipeline: RD issues the address, RAM answers a cycle later,
            // then the word is registered towards the display.
            rd_v1          <= (state == RD);
            rd_v2          <= rd_v1;
            bus.disp_valid <= rd_v2;
            if (rd_v2)
                bus.disp_data <= bus.mem_rdata;

            bus.mem_addr  <= mem_addr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
            bus.mem_we    <= mem_we_nxt;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_nxt;
            bus.wr_err <= accept && !in_range;

            if (frame_start)
                stall_cnt <= '0;
            else if (bus.disp_req && (fifo_count != '0) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock_25) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_arbitro_memoria_vga.sv
// Scoreboard bench for arbitro_memoria_vga: reads and writes are queued as issued
// and checked by a negedge monitor against a behavioural RAM.
module tb_arbitro_memoria_vga;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  fifo_count;
    logic [15:0] stall_cnt;

    arbitro_memoria_vga_if #(.ADDR_W(18), .DATA_W(24)) bus ();

    arbitro_memoria_vga #(
        .ADDR_W(18), .DATA_W(24), .MEM_WORDS(160000), .FIFO_DEPTH(4)
    ) dut (
        .clock_25   (clk),
        .reset      (rst_n),
        .bus        (bus),
        .frame_start(frame_start),
        .fifo_count (fifo_count),
        .stall_cnt  (stall_cnt)
    );

    always #20 clk = ~clk;

    typedef struct {logic [23:0] data; int unsigned cyc;} rd_exp_t;
    typedef struct {logic [17:0] addr; logic [23:0] data;} wr_exp_t;

    rd_exp_t     rd_q[$];
    wr_exp_t     wr_q[$];
    rd_exp_t     re;
    wr_exp_t     we_e;
    int          compared = 0;
    int          mismatched = 0;
    int unsigned cyc = 0;
    logic [23:0] ram [int unsigned];

    function automatic logic [23:0] init_val(logic [17:0] a);
        if (a == 18'h00123) return 24'hABCDEF;
        return {6'h2A, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sync RAM: data for mem_addr appears one edge later.
    always @(posedge clk) begin
        if (bus.mem_we) ram[32'(bus.mem_addr)] = bus.mem_wdata;
        bus.mem_rdata <= ram.exists(32'(bus.mem_addr)) ? ram[32'(bus.mem_addr)]
                                                        : init_val(bus.mem_addr);
    end

    // Each sampled read request must come back three edges after sampling.
    always @(posedge clk)
        if (rst_n && bus.disp_req) rd_q.push_back('{init_val(bus.disp_addr), cyc + 4});

    always @(negedge clk) begin
        if (rst_n && bus.disp_valid) begin
            compared++;
            if (rd_q.size() == 0) begin
                mismatched++;
                $display("FAIL disp_unexpected got data=%h cyc=%0d required no pulse", bus.disp_data, cyc);
            end else begin
                re = rd_q.pop_front();
                if (bus.disp_data !== re.data || cyc != re.cyc) begin
                    mismatched++;
                    $display("FAIL disp_read got data=%h cyc=%0d required data=%h cyc=%0d",
                             bus.disp_data, cyc, re.data, re.cyc);
                end
            end
        end
        if (rst_n && bus.mem_we) begin
            compared++;
            if (wr_q.size() == 0) begin
                mismatched++;
                $display("FAIL mem_we_unexpected got addr=%h data=%h required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                we_e = wr_q.pop_front();
                if (bus.mem_addr !== we_e.addr || bus.mem_wdata !== we_e.data) begin
                    mismatched++;
                    $display("FAIL mem_write got addr=%h data=%h required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, we_e.addr, we_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [17:0] a, input logic [23:0] d);
        int unsigned guard = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        while (!bus.wr_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("wr_ready_before_push", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [17:0] a, input logic [23:0] d);
        wr_q.push_back('{a, d});
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        tick(3);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_wr_ready", 32'(bus.wr_ready), 1);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_disp_valid", 32'(bus.disp_valid), 0);
        check("rst_wr_err", 32'(bus.wr_err), 0);
        rst_n = 1'b1;
        tick(2);

        // Reset while three writes are parked behind display reads
        bus.disp_req  = 1'b1;
        bus.disp_addr = 18'h03000;
        for (int i = 0; i < 3; i++) push_word(18'h00800 + 18'(i), 24'h550000 + 24'(i));
        check("t1_count_before", 32'(fifo_count), 3);
        #5 rst_n = 1'b0;
        #1;
        rd_q.delete();
        check("t1_count_in_reset", 32'(fifo_count), 0);
        check("t1_ready_in_reset", 32'(bus.wr_ready), 1);
        check("t1_stall_in_reset", 32'(stall_cnt), 0);
        check("t1_we_in_reset", 32'(bus.mem_we), 0);
        bus.disp_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(10);
        check("t1_count_after", 32'(fifo_count), 0);

        // Single read then eight back-to-back reads
        bus.disp_req  = 1'b1;
        bus.disp_addr = 18'h00123;
        tick();
        bus.disp_req = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = 18'h00200 + 18'(i);
            tick();
        end
        bus.disp_req = 1'b0;
        tick(5);

        // FIFO fills under a continuous display stream, then drains in order
        bus.disp_req  = 1'b1;
        bus.disp_addr = 18'h03000;
        for (int i = 0; i < 5; i++) expect_write(18'h01000 + 18'(i), 24'h110000 + 24'(i));
        for (int i = 0; i < 4; i++) push_word(18'h01000 + 18'(i), 24'h110000 + 24'(i));
        check("t3_count_full", 32'(fifo_count), 4);
        check("t3_ready_full", 32'(bus.wr_ready), 0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 18'h01004;
        bus.wr_data  = 24'h110004;
        tick();
        check("t3_count_held", 32'(fifo_count), 4);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t3_stall_clr", 32'(stall_cnt), 0);
        tick(5);
        check("t3_stall_rise", 32'(stall_cnt), 5);
        bus.disp_req = 1'b0;
        tick();
        check("t3_we_wait", 32'(bus.mem_we), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_we_pulse", 32'(bus.mem_we), 1);
            if (i == 0) check("t3_ready_after_pop", 32'(bus.wr_ready), 1);
            if (i == 1) begin
                bus.wr_valid = 1'b0;
                check("t3_count_push_pop", 32'(fifo_count), 3);
            end
        end
        tick(3);
        check("t3_count_drained", 32'(fifo_count), 0);

        // Out-of-range address rejected, in-range neighbour accepted
        push_word(18'd160000, 24'hDEAD01);
        check("t4_err_pulse", 32'(bus.wr_err), 1);
        check("t4_count_rejected", 32'(fifo_count), 0);
        tick();
        check("t4_err_clear", 32'(bus.wr_err), 0);
        expect_write(18'd159999, 24'hBEEF02);
        push_word(18'd159999, 24'hBEEF02);
        check("t4_err_none", 32'(bus.wr_err), 0);
        check("t4_count_one", 32'(fifo_count), 1);
        tick(3);
        check("t4_count_drained", 32'(fifo_count), 0);

        // Push and pop in the same cycle at two entries
        bus.disp_req = 1'b1;
        for (int i = 0; i < 4; i++) expect_write(18'h01100 + 18'(i), 24'h220000 + 24'(i));
        for (int i = 0; i < 3; i++) push_word(18'h01100 + 18'(i), 24'h220000 + 24'(i));
        check("t5_count_three", 32'(fifo_count), 3);
        bus.disp_req = 1'b0;
        tick();
        check("t5_count_no_pop_yet", 32'(fifo_count), 3);
        tick();
        check("t5_count_two", 32'(fifo_count), 2);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 18'h01103;
        bus.wr_data  = 24'h220003;
        tick();
        bus.wr_valid = 1'b0;
        check("t5_count_push_pop", 32'(fifo_count), 2);
        tick(5);
        check("t5_count_drained", 32'(fifo_count), 0);

        // stall_cnt saturation and frame_start priority
        bus.disp_req = 1'b1;
        expect_write(18'h01200, 24'h330000);
        push_word(18'h01200, 24'h330000);
        check("t6_count_one", 32'(fifo_count), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_stall_clr", 32'(stall_cnt), 0);
        tick(65535);
        check("t6_stall_max", 32'(stall_cnt), 32'hFFFF);
        tick(3);
        check("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_stall_frame", 32'(stall_cnt), 0);
        tick();
        check("t6_stall_restart", 32'(stall_cnt), 1);
        bus.disp_req = 1'b0;
        tick(5);
        check("t6_count_drained", 32'(fifo_count), 0);

        tick(5);
        check("rd_queue_empty", 32'(rd_q.size()), 0);
        check("wr_queue_empty", 32'(wr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
